// File: rtl/vid_timing_gen.sv
// vid_timing_gen: programmable raster timing generator.
// Produces hsyn/vsyn/de, replicated logical pixel coordinates (x, y), a
// per-pixel advance strobe, a line-start pulse and a sticky frame interrupt.
// Timing registers are written to a staging set and copied to the active set
// at frame end (or continuously while disabled), so a retime never tears a frame.
//
// Ports:
//   clk_data             sole clock, rising edge
//   irst                 synchronous active-high reset
//   reg_en/reg_we        register strobe / write select
//   reg_addr/reg_wdata   register index / write data
//   reg_rdata            read data, valid the cycle after a read strobe
//   hsyn, vsyn           syncs, polarity from CTRL.hpol / CTRL.vpol
//   de                   active-video enable
//   x, y                 logical pixel column / row
//   pix_adv              strobe on the last clock of each logical pixel
//   line_start           pulse when hcnt==0
//   frame_irq            sticky frame-end interrupt
module vid_timing_gen #(
    parameter int CW   = 12,
    parameter int DIVW = 4
) (
    input  logic          clk_data,
    input  logic          irst,
    input  logic          reg_en,
    input  logic          reg_we,
    input  logic [3:0]    reg_addr,
    input  logic [31:0]   reg_wdata,
    output logic [31:0]   reg_rdata,
    output logic          hsyn,
    output logic          vsyn,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_adv,
    output logic          line_start,
    output logic          frame_irq
);

    localparam logic [CW-1:0]   RST_HSS  = CW'(1048);
    localparam logic [CW-1:0]   RST_HSE  = CW'(1184);
    localparam logic [CW-1:0]   RST_HTOT = CW'(1343);
    localparam logic [CW-1:0]   RST_VSS  = CW'(771);
    localparam logic [CW-1:0]   RST_VSE  = CW'(777);
    localparam logic [CW-1:0]   RST_VTOT = CW'(805);
    localparam logic [CW-1:0]   RST_HAE  = CW'(1024);
    localparam logic [CW-1:0]   RST_VAE  = CW'(768);
    localparam logic [CW-1:0]   CW_ONE   = CW'(1);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);

    logic [CW-1:0]   s_hss, s_hse, s_htot, s_vss, s_vse, s_vtot, s_has, s_hae, s_vas, s_vae;
    logic [CW-1:0]   a_hss, a_hse, a_htot, a_vss, a_vse, a_vtot, a_has, a_hae, a_vas, a_vae;
    logic [DIVW-1:0] s_hdiv, s_vdiv, a_hdiv, a_vdiv;
    logic            en, hpol, vpol, irq_en;
    logic [CW-1:0]   hcnt, vcnt, xcnt, ycnt;
    logic [DIVW-1:0] hsub, vsub;
    logic [15:0]     frame_cnt;
    logic [31:0]     rd_mux;
    logic            wr, en_nxt, run, h_last, frame_end;
    logic            hs_c, vs_c, hwin, vwin, de_c;
    logic            unused_wdata;

    assign unused_wdata = ^reg_wdata[31:CW];

    assign wr        = reg_en && reg_we;
    // A CTRL write clearing en must already stop the counters at this edge.
    assign en_nxt    = (wr && reg_addr == 4'd11) ? reg_wdata[0] : en;
    assign run       = en && en_nxt;
    assign h_last    = (hcnt == a_htot);
    assign frame_end = en && h_last && (vcnt == a_vtot);

    assign hs_c = (hcnt >= a_hss) && (hcnt < a_hse);
    assign vs_c = (vcnt >= a_vss) && (vcnt < a_vse);
    assign hwin = (hcnt >= a_has) && (hcnt < a_hae);
    assign vwin = (vcnt >= a_vas) && (vcnt < a_vae);
    assign de_c = hwin && vwin;

    always_ff @(posedge clk_data) begin
        if (irst) begin
            s_hss  <= RST_HSS;  s_hse <= RST_HSE;  s_htot <= RST_HTOT;
            s_vss  <= RST_VSS;  s_vse <= RST_VSE;  s_vtot <= RST_VTOT;
            s_has  <= '0;       s_hae <= RST_HAE;  s_vas  <= '0;
            s_vae  <= RST_VAE;  s_hdiv <= '0;      s_vdiv <= '0;
            en     <= 1'b1;     hpol  <= 1'b0;     vpol   <= 1'b0;
            irq_en <= 1'b0;
        end else if (wr) begin
            case (reg_addr)
                4'd0:  s_hss  <= reg_wdata[CW-1:0];
                4'd1:  s_hse  <= reg_wdata[CW-1:0];
                4'd2:  s_htot <= reg_wdata[CW-1:0];
                4'd3:  s_vss  <= reg_wdata[CW-1:0];
                4'd4:  s_vse  <= reg_wdata[CW-1:0];
                4'd5:  s_vtot <= reg_wdata[CW-1:0];
                4'd6:  s_has  <= reg_wdata[CW-1:0];
                4'd7:  s_hae  <= reg_wdata[CW-1:0];
                4'd8:  s_vas  <= reg_wdata[CW-1:0];
                4'd9:  s_vae  <= reg_wdata[CW-1:0];
                4'd10: begin
                    s_hdiv <= reg_wdata[DIVW-1:0];
                    s_vdiv <= reg_wdata[DIVW+7:8];
                end
                4'd11: {irq_en, vpol, hpol, en} <= reg_wdata[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_data) begin
        if (irst) begin
            a_hss  <= RST_HSS;  a_hse <= RST_HSE;  a_htot <= RST_HTOT;
            a_vss  <= RST_VSS;  a_vse <= RST_VSE;  a_vtot <= RST_VTOT;
            a_has  <= '0;       a_hae <= RST_HAE;  a_vas  <= '0;
            a_vae  <= RST_VAE;  a_hdiv <= '0;      a_vdiv <= '0;
        end else if (frame_end || !en) begin
            a_hss  <= s_hss;  a_hse <= s_hse;  a_htot <= s_htot;
            a_vss  <= s_vss;  a_vse <= s_vse;  a_vtot <= s_vtot;
            a_has  <= s_has;  a_hae <= s_hae;  a_vas  <= s_vas;
            a_vae  <= s_vae;  a_hdiv <= s_hdiv; a_vdiv <= s_vdiv;
        end
    end

    always_ff @(posedge clk_data) begin
        if (irst || !run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= (vcnt == a_vtot) ? '0 : vcnt + CW_ONE;
        end else begin
            hcnt <= hcnt + CW_ONE;
        end
    end

    always_ff @(posedge clk_data) begin
        if (irst || !run) begin
            hsub <= '0;
            xcnt <= '0;
            vsub <= '0;
            ycnt <= '0;
        end else begin
            if (de_c) begin
                if (hsub == a_hdiv) begin
                    hsub <= '0;
                    xcnt <= xcnt + CW_ONE;
                end else begin
                    hsub <= hsub + DIV_ONE;
                end
            end else if (!hwin) begin
                hsub <= '0;
                xcnt <= '0;
            end
            if (!vwin) begin
                vsub <= '0;
                ycnt <= '0;
            end else if (h_last) begin
                if (vsub == a_vdiv) begin
                    vsub <= '0;
                    ycnt <= ycnt + CW_ONE;
                end else begin
                    vsub <= vsub + DIV_ONE;
                end
            end
        end
    end

    // Outputs show the counter state of the previous cycle.
    always_ff @(posedge clk_data) begin
        if (irst) begin
            hsyn       <= 1'b0;
            vsyn       <= 1'b0;
            de         <= 1'b0;
            pix_adv    <= 1'b0;
            line_start <= 1'b0;
            x          <= '0;
            y          <= '0;
        end else begin
            hsyn       <= (hs_c && run) ^ hpol;
            vsyn       <= (vs_c && run) ^ vpol;
            de         <= de_c && run;
            pix_adv    <= de_c && run && (hsub == a_hdiv);
            line_start <= run && (hcnt == '0);
            x          <= run ? xcnt : '0;
            y          <= run ? ycnt : '0;
        end
    end

    // A frame-end set beats a simultaneous STATUS clear.
    always_ff @(posedge clk_data) begin
        if (irst) begin
            frame_cnt <= '0;
            frame_irq <= 1'b0;
        end else begin
            if (frame_end)
                frame_cnt <= frame_cnt + 16'd1;
            if (frame_end && irq_en)
                frame_irq <= 1'b1;
            else if (wr && reg_addr == 4'd12 && reg_wdata[0])
                frame_irq <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            4'd0:  rd_mux[CW-1:0] = s_hss;
            4'd1:  rd_mux[CW-1:0] = s_hse;
            4'd2:  rd_mux[CW-1:0] = s_htot;
            4'd3:  rd_mux[CW-1:0] = s_vss;
            4'd4:  rd_mux[CW-1:0] = s_vse;
            4'd5:  rd_mux[CW-1:0] = s_vtot;
            4'd6:  rd_mux[CW-1:0] = s_has;
            4'd7:  rd_mux[CW-1:0] = s_hae;
            4'd8:  rd_mux[CW-1:0] = s_vas;
            4'd9:  rd_mux[CW-1:0] = s_vae;
            4'd10: begin
                rd_mux[DIVW-1:0]   = s_hdiv;
                rd_mux[DIVW+7:8]   = s_vdiv;
            end
            4'd11: rd_mux[3:0]    = {irq_en, vpol, hpol, en};
            4'd12: rd_mux         = {frame_cnt, 15'd0, frame_irq};
            4'd13: rd_mux[CW-1:0] = vcnt;
            default: ;
        endcase
    end

    always_ff @(posedge clk_data) begin
        if (irst)
            reg_rdata <= '0;
        else if (reg_en && !reg_we)
            reg_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
module tb_vid_timing_gen;

    localparam int CW = 12;

    logic          clk_data = 1'b0;
    logic          irst = 1'b1;
    logic          reg_en = 1'b0;
    logic          reg_we = 1'b0;
    logic [3:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          hsyn, vsyn, de, pix_adv, line_start, frame_irq;
    logic [CW-1:0] x, y;

    int n_chk = 0;
    int n_fail = 0;
    int fc_model = 0;

    always #5 clk_data = ~clk_data;

    vid_timing_gen #(.CW(CW), .DIVW(4)) dut (
        .clk_data(clk_data), .irst(irst),
        .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .hsyn(hsyn), .vsyn(vsyn), .de(de), .x(x), .y(y),
        .pix_adv(pix_adv), .line_start(line_start), .frame_irq(frame_irq)
    );

    typedef struct {
        logic [CW-1:0] hss, hse, htot, vss, vse, vtot, has, hae, vas, vae;
        logic [3:0]    hdiv, vdiv;
        logic [3:0]    ctrl;
    } cfg_t;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } rv_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic reg_access(input bit we, input logic [3:0] addr, input logic [31:0] wdata);
        @(negedge clk_data);
        reg_en = 1'b1; reg_we = we; reg_addr = addr; reg_wdata = wdata;
        @(negedge clk_data);
        reg_en = 1'b0; reg_we = 1'b0;
    endtask

    // Expected {hsyn,vsyn,de,pix_adv,line_start,frame_irq,x,y} for counter state (hc,vc).
    function automatic logic [29:0] model(input cfg_t a, input int hc, input int vc,
                                          input bit on, input bit irq);
        logic hs, vs, d, pa, ls;
        int   hd, vd, xx, yy;
        if (!on) return {a.ctrl[1], a.ctrl[2], 3'b000, irq, 24'd0};
        hd = int'(a.hdiv) + 1;
        vd = int'(a.vdiv) + 1;
        hs = ((hc >= int'(a.hss)) && (hc < int'(a.hse))) ^ a.ctrl[1];
        vs = ((vc >= int'(a.vss)) && (vc < int'(a.vse))) ^ a.ctrl[2];
        d  = (hc >= int'(a.has)) && (hc < int'(a.hae)) && (vc >= int'(a.vas)) && (vc < int'(a.vae));
        pa = d && (((hc - int'(a.has)) % hd) == hd - 1);
        ls = (hc == 0);
        xx = d ? (hc - int'(a.has)) / hd : 0;
        yy = d ? (vc - int'(a.vas)) / vd : 0;
        return {hs, vs, d, pa, ls, irq, 12'(xx), 12'(yy)};
    endfunction

    task automatic restart(input cfg_t c);
        reg_access(1'b1, 4'd11, {28'd0, c.ctrl & 4'b1110});
        reg_access(1'b1, 4'd0, {20'd0, c.hss});
        reg_access(1'b1, 4'd1, {20'd0, c.hse});
        reg_access(1'b1, 4'd2, {20'd0, c.htot});
        reg_access(1'b1, 4'd3, {20'd0, c.vss});
        reg_access(1'b1, 4'd4, {20'd0, c.vse});
        reg_access(1'b1, 4'd5, {20'd0, c.vtot});
        reg_access(1'b1, 4'd6, {20'd0, c.has});
        reg_access(1'b1, 4'd7, {20'd0, c.hae});
        reg_access(1'b1, 4'd8, {20'd0, c.vas});
        reg_access(1'b1, 4'd9, {20'd0, c.vae});
        reg_access(1'b1, 4'd10, {20'd0, c.vdiv, 4'd0, c.hdiv});
        reg_access(1'b1, 4'd12, 32'd1);
        reg_access(1'b1, 4'd11, {28'd0, c.ctrl});
    endtask

    // Iteration k samples outputs that reflect counter position k after enable.
    task automatic run_check(input string tag, input cfg_t c, input cfg_t cn, input int ncyc,
                             input int wr_k, input logic [3:0] wr_addr, input logic [31:0] wr_data,
                             input int dis_k, input int rd_k, input logic [3:0] rd_addr,
                             input logic [31:0] rd_exp);
        bit irq_m;
        int per;
        irq_m = 1'b0;
        per = (int'(c.htot) + 1) * (int'(c.vtot) + 1);
        for (int k = 0; k < ncyc; k++) begin
            cfg_t        a;
            int          hc, vc;
            bit          on;
            logic [29:0] e, g;
            @(negedge clk_data);
            a  = (k >= per) ? cn : c;
            hc = k % (int'(a.htot) + 1);
            vc = (k / (int'(a.htot) + 1)) % (int'(a.vtot) + 1);
            on = (dis_k < 0) || (k < dis_k);
            if (on && hc == int'(a.htot) && vc == int'(a.vtot)) begin
                fc_model++;
                if (c.ctrl[3]) irq_m = 1'b1;
            end else if (wr_addr == 4'd12 && wr_data[0] && k == wr_k + 1) begin
                irq_m = 1'b0;
            end
            e = model(a, hc, vc, on, irq_m);
            g = {hsyn, vsyn, de, pix_adv, line_start, frame_irq,
                 e[27] ? x : {CW{1'b0}}, e[27] ? y : {CW{1'b0}}};
            check($sformatf("%s k=%0d", tag, k), {2'b00, g}, {2'b00, e});
            if (rd_k >= 0 && k == rd_k + 1)
                check({tag, " rdata"}, reg_rdata, rd_exp);
            if (k == wr_k) begin
                reg_en = 1'b1; reg_we = 1'b1; reg_addr = wr_addr; reg_wdata = wr_data;
            end else if (k == rd_k) begin
                reg_en = 1'b1; reg_we = 1'b0; reg_addr = rd_addr;
            end else begin
                reg_en = 1'b0; reg_we = 1'b0;
            end
        end
        reg_en = 1'b0; reg_we = 1'b0;
    endtask

    initial begin
        rv_t  tbl[$];
        cfg_t b, r, cn, ip, p;
        logic [15:0] f;

        tbl.push_back('{1'b0, 4'd0,  32'd0,          32'd1048});
        tbl.push_back('{1'b0, 4'd1,  32'd0,          32'd1184});
        tbl.push_back('{1'b0, 4'd2,  32'd0,          32'd1343});
        tbl.push_back('{1'b0, 4'd3,  32'd0,          32'd771});
        tbl.push_back('{1'b0, 4'd4,  32'd0,          32'd777});
        tbl.push_back('{1'b0, 4'd5,  32'd0,          32'd805});
        tbl.push_back('{1'b0, 4'd6,  32'd0,          32'd0});
        tbl.push_back('{1'b0, 4'd7,  32'd0,          32'd1024});
        tbl.push_back('{1'b0, 4'd8,  32'd0,          32'd0});
        tbl.push_back('{1'b0, 4'd9,  32'd0,          32'd768});
        tbl.push_back('{1'b0, 4'd10, 32'd0,          32'd0});
        tbl.push_back('{1'b0, 4'd12, 32'd0,          32'd0});
        tbl.push_back('{1'b0, 4'd13, 32'd0,          32'd0});
        tbl.push_back('{1'b0, 4'd14, 32'd0,          32'd0});
        tbl.push_back('{1'b1, 4'd14, 32'hDEAD_BEEF,  32'd0});
        tbl.push_back('{1'b0, 4'd14, 32'd0,          32'd0});
        tbl.push_back('{1'b1, 4'd10, 32'hFFFF_F3A5,  32'd0});
        tbl.push_back('{1'b0, 4'd10, 32'd0,          32'h0000_0305});
        tbl.push_back('{1'b1, 4'd7,  32'hFFFF_F123,  32'd0});
        tbl.push_back('{1'b0, 4'd7,  32'd0,          32'h0000_0123});
        tbl.push_back('{1'b1, 4'd13, 32'h0000_0055,  32'd0});
        tbl.push_back('{1'b0, 4'd13, 32'd0,          32'd0});
        tbl.push_back('{1'b1, 4'd15, 32'h0000_0001,  32'd0});
        tbl.push_back('{1'b0, 4'd15, 32'd0,          32'd0});

        repeat (3) @(negedge clk_data);
        check("reset outputs", {2'b00, hsyn, vsyn, de, pix_adv, line_start, frame_irq, x, y}, 32'd0);
        check("reset rdata", reg_rdata, 32'd0);
        irst = 1'b0;

        foreach (tbl[i]) begin
            reg_access(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].we)
                check($sformatf("reg[%0d] read", tbl[i].addr), reg_rdata, tbl[i].exp);
        end

        b.hss = 12'd7; b.hse = 12'd9; b.htot = 12'd9;
        b.vss = 12'd3; b.vse = 12'd4; b.vtot = 12'd4;
        b.has = 12'd2; b.hae = 12'd6; b.vas = 12'd1; b.vae = 12'd3;
        b.hdiv = 4'd0; b.vdiv = 4'd0; b.ctrl = 4'b0001;

        restart(b);
        f = 16'(fc_model + 2);
        run_check("base", b, b, 110, -1, 4'd0, 32'd0, -1, 105, 4'd12, {f, 15'd0, 1'b0});

        r = b;
        r.hdiv = 4'd1; r.vdiv = 4'd1;
        r.hss = 12'd7; r.hse = 12'd7;
        r.vss = 12'd5; r.vse = 12'd6;
        restart(r);
        run_check("repl", r, r, 60, -1, 4'd0, 32'd0, -1, -1, 4'd0, 32'd0);

        cn = b;
        cn.hae = 12'd5;
        restart(b);
        run_check("shadow", b, cn, 110, 20, 4'd7, 32'd5, -1, 21, 4'd7, 32'd5);

        ip = b;
        ip.ctrl = 4'b1001;
        restart(ip);
        f = 16'(fc_model + 2);
        run_check("irq", ip, ip, 115, 98, 4'd12, 32'd1, -1, 110, 4'd12, {f, 15'd0, 1'b1});
        reg_access(1'b1, 4'd12, 32'd1);
        reg_access(1'b0, 4'd12, 32'd0);
        check("irq clear", reg_rdata, {16'(fc_model), 15'd0, 1'b0});

        p = b;
        p.ctrl = 4'b0111;
        restart(p);
        run_check("pol", p, p, 40, 23, 4'd11, 32'h6, 24, 30, 4'd13, 32'd0);

        restart(b);
        run_check("pre-reset", b, b, 4, -1, 4'd0, 32'd0, -1, -1, 4'd0, 32'd0);
        @(negedge clk_data);
        irst = 1'b1;
        @(negedge clk_data);
        check("mid-line reset outputs",
              {2'b00, hsyn, vsyn, de, pix_adv, line_start, frame_irq, x, y}, 32'd0);
        check("mid-line reset rdata", reg_rdata, 32'd0);
        irst = 1'b0;
        reg_access(1'b0, 4'd2, 32'd0);
        check("post-reset HTOT", reg_rdata, 32'd1343);
        reg_access(1'b0, 4'd7, 32'd0);
        check("post-reset HAE", reg_rdata, 32'd1024);
        reg_access(1'b0, 4'd13, 32'd0);
        check("post-reset VCNT", reg_rdata, 32'd0);
        reg_access(1'b0, 4'd12, 32'd0);
        check("post-reset STATUS", reg_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
